// File: rtl/pulse_train_gen_if.sv
// ---------------------------------------------------------------------------
// pulse_train_gen_if
//   Configuration write port of pulse_train_gen.
//
//   Handshake: cfg_we is a single-cycle write strobe with no ready/back
//   pressure. When cfg_we is high at a rising clk edge, cfg_addr / cfg_ch /
//   cfg_data are sampled on that same edge and the write is complete. The
//   slave never stalls. cfg_pend and cfg_err are registered status outputs.
//
//   Signals (master = config host, slave = pulse_train_gen):
//     cfg_we    master->slave  write strobe, one cycle
//     cfg_addr  master->slave  0 period, 1 delay, 2 width, 3 polarity
//     cfg_ch    master->slave  channel select for addr 1..3
//     cfg_data  master->slave  write data
//     cfg_pend  slave->master  shadow writes not yet applied
//     cfg_err   slave->master  sticky invalid-write flag
// ---------------------------------------------------------------------------
interface pulse_train_gen_if #(
    parameter int CH    = 2,
    parameter int CNT_W = 23
);
    localparam int CH_W = (CH > 1) ? $clog2(CH) : 1;

    logic             cfg_we;
    logic [1:0]       cfg_addr;
    logic [CH_W-1:0]  cfg_ch;
    logic [CNT_W-1:0] cfg_data;
    logic             cfg_pend;
    logic             cfg_err;

    modport master (
        output cfg_we, cfg_addr, cfg_ch, cfg_data,
        input  cfg_pend, cfg_err
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_ch, cfg_data,
        output cfg_pend, cfg_err
    );
endinterface

// File: rtl/pulse_train_gen.sv
// ---------------------------------------------------------------------------
// pulse_train_gen
//   Multi-channel programmable pulse generator. One shared period counter;
//   each channel emits one pulse per period with its own delay and width.
//   Period/delay/width (and optional polarity) are written into shadow
//   registers and copied to the active set at a period boundary (counter
//   wrap or sync), or continuously while disabled.
//
//   Optional feature macro: PULSE_GEN_POL_EN
//     defined   -> per-channel output polarity register (addr 3, bit 0)
//     undefined -> active-high outputs; addr 3 writes are silently ignored
//
//   Ports:
//     clk    in   system clock
//     rst_n  in   asynchronous active-low reset
//     en     in   run enable
//     sync   in   synchronous period restart strobe
//     cfg    if   configuration write port (pulse_train_gen_if.slave)
//     pulse  out  CH registered pulse outputs
//     tick   out  registered one-cycle strobe at period start
// ---------------------------------------------------------------------------
module pulse_train_gen #(
    parameter int CH        = 2,
    parameter int CNT_W     = 23,
    parameter int PERIOD    = 5_000_000,
    parameter int DEF_WIDTH = 5,
    parameter int DEF_DELAY = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 sync,
    pulse_train_gen_if.slave     cfg,
    output logic [CH-1:0]        pulse,
    output logic                 tick
);
    localparam int CH_W = (CH > 1) ? $clog2(CH) : 1;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] per_a, per_s;
    logic [CNT_W-1:0] dly_a [CH];
    logic [CNT_W-1:0] dly_s [CH];
    logic [CNT_W-1:0] wid_a [CH];
    logic [CNT_W-1:0] wid_s [CH];
    logic [CH-1:0]    raw;
    logic             pend_q, err_q;

    logic wrap, apply;
    logic ch_ok, wr_per, wr_dly, wr_wid, wr_pol, wr_bad, wr_ok;

    // Boundary detection. While disabled every cycle counts as a boundary so
    // the active set tracks the shadows.
    assign wrap  = (cnt == per_a - 1'b1);
    assign apply = !en || sync || wrap;

    // Write decode. Invalid writes touch no shadow and do not set pending.
    always_comb begin
        ch_ok  = (int'(cfg.cfg_ch) < CH);
        wr_per = cfg.cfg_we && (cfg.cfg_addr == 2'd0) && (cfg.cfg_data >= CNT_W'(2));
        wr_dly = cfg.cfg_we && (cfg.cfg_addr == 2'd1) && ch_ok;
        wr_wid = cfg.cfg_we && (cfg.cfg_addr == 2'd2) && ch_ok;
`ifdef PULSE_GEN_POL_EN
        wr_pol = cfg.cfg_we && (cfg.cfg_addr == 2'd3) && ch_ok;
        wr_bad = cfg.cfg_we &&
                 (((cfg.cfg_addr == 2'd0) && (cfg.cfg_data < CNT_W'(2))) ||
                  ((cfg.cfg_addr != 2'd0) && !ch_ok));
`else
        wr_pol = 1'b0;
        wr_bad = cfg.cfg_we &&
                 (((cfg.cfg_addr == 2'd0) && (cfg.cfg_data < CNT_W'(2))) ||
                  (((cfg.cfg_addr == 2'd1) || (cfg.cfg_addr == 2'd2)) && !ch_ok));
`endif
        wr_ok  = wr_per || wr_dly || wr_wid || wr_pol;
    end

    // Pulse window. The end bound is formed one bit wider so delay+width can
    // never wrap; windows running past per-1 are cut off naturally because
    // cnt never exceeds per-1.
    always_comb begin
        raw = '0;
        for (int i = 0; i < CH; i++) begin
            raw[i] = (cnt >= dly_a[i]) &&
                     ({1'b0, cnt} < ({1'b0, dly_a[i]} + {1'b0, wid_a[i]}));
        end
    end

`ifdef PULSE_GEN_POL_EN
    logic [CH-1:0] pol_a, pol_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pol_a <= '0;
            pol_s <= '0;
        end else begin
            if (apply) pol_a <= pol_s;
            for (int i = 0; i < CH; i++) begin
                if (wr_pol && (cfg.cfg_ch == CH_W'(i))) pol_s[i] <= cfg.cfg_data[0];
            end
        end
    end
`else
    logic [CH-1:0] pol_a;
    assign pol_a = '0;
`endif

    // Counter and registered outputs. Idle level of each pulse is its
    // active polarity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            pulse <= '0;
            tick  <= 1'b0;
        end else if (!en || sync) begin
            cnt   <= '0;
            pulse <= pol_a;
            tick  <= 1'b0;
        end else begin
            cnt   <= wrap ? '0 : cnt + 1'b1;
            pulse <= raw ^ pol_a;
            tick  <= (cnt == '0);
        end
    end

    // Shadow/active configuration. A write on the apply edge lands in the
    // shadow only; the active copy takes the pre-write shadow value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_a <= CNT_W'(PERIOD);
            per_s <= CNT_W'(PERIOD);
            for (int i = 0; i < CH; i++) begin
                dly_a[i] <= CNT_W'(DEF_DELAY);
                dly_s[i] <= CNT_W'(DEF_DELAY);
                wid_a[i] <= CNT_W'(DEF_WIDTH);
                wid_s[i] <= CNT_W'(DEF_WIDTH);
            end
        end else begin
            if (apply) begin
                per_a <= per_s;
                for (int i = 0; i < CH; i++) begin
                    dly_a[i] <= dly_s[i];
                    wid_a[i] <= wid_s[i];
                end
            end
            if (wr_per) per_s <= cfg.cfg_data;
            for (int i = 0; i < CH; i++) begin
                if (wr_dly && (cfg.cfg_ch == CH_W'(i))) dly_s[i] <= cfg.cfg_data;
                if (wr_wid && (cfg.cfg_ch == CH_W'(i))) wid_s[i] <= cfg.cfg_data;
            end
        end
    end

    // Status flags. A write on the apply edge keeps pending set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            if (wr_ok)      pend_q <= 1'b1;
            else if (apply) pend_q <= 1'b0;
            if (wr_bad)     err_q  <= 1'b1;
        end
    end

    assign cfg.cfg_pend = pend_q;
    assign cfg.cfg_err  = err_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
// ---------------------------------------------------------------------------
// tb_pulse_train_gen
//   Directed bench for pulse_train_gen (CH=3, CNT_W=8, PERIOD=20,
//   DEF_WIDTH=5, DEF_DELAY=0). Expected {cfg_err, cfg_pend, tick, pulse}
//   values are pushed per cycle number; a monitor on the falling edge pops
//   and compares whenever the cycle counter reaches the queued cycle.
// ---------------------------------------------------------------------------
module tb_pulse_train_gen;
    localparam int CH    = 3;
    localparam int CNT_W = 8;
    localparam int W     = CH + 3;
    localparam int NONE  = 1000;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    logic en;
    logic sync;
    logic [CH-1:0] pulse;
    logic tick;

    always #5 clk = ~clk;

    pulse_train_gen_if #(.CH(CH), .CNT_W(CNT_W)) cfg_if ();

    pulse_train_gen #(
        .CH(CH), .CNT_W(CNT_W), .PERIOD(20), .DEF_WIDTH(5), .DEF_DELAY(0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .sync  (sync),
        .cfg   (cfg_if),
        .pulse (pulse),
        .tick  (tick)
    );

    // Cycle number = count of rising edges seen with reset released.
    int cyc = 0;
    always @(posedge clk) if (rst_n) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    int             exp_cyc_q[$];
    logic [W-1:0]   exp_q[$];
    int             n_vec  = 0;
    int             n_fail = 0;
    int             win_lo[CH];
    int             win_hi[CH];

    task automatic push_exp(input int c, input logic [W-1:0] v);
        exp_cyc_q.push_back(c);
        exp_q.push_back(v);
    endtask

    task automatic set_win(input int ch, input int lo, input int hi);
        win_lo[ch] = lo;
        win_hi[ch] = hi;
    endtask

    // Offsets k = 1..n within a period that starts (tick) at cycle 'start'.
    task automatic push_period(input int start, input int n, input logic [CH-1:0] pol,
                               input int pend_lo, input int pend_hi, input int err_lo);
        logic [W-1:0] v;
        for (int k = 1; k <= n; k++) begin
            for (int i = 0; i < CH; i++)
                v[i] = ((k >= win_lo[i]) && (k <= win_hi[i])) ^ pol[i];
            v[CH]   = (k == 1);
            v[CH+1] = (k >= pend_lo) && (k <= pend_hi);
            v[CH+2] = (k >= err_lo);
            push_exp(start + k - 1, v);
        end
    endtask

    always @(negedge clk) begin
        logic [W-1:0] act;
        logic [W-1:0] e;
        int           c;
        act = {cfg_if.cfg_err, cfg_if.cfg_pend, tick, pulse};
        while (exp_cyc_q.size() > 0 && exp_cyc_q[0] <= cyc) begin
            c = exp_cyc_q.pop_front();
            e = exp_q.pop_front();
            n_vec++;
            if (c != cyc) begin
                n_fail++;
                $display("FAIL missed_vector cyc=%0d queued_for=%0d exp=%b", cyc, c, e);
            end else if (act !== e) begin
                n_fail++;
                $display("FAIL outputs cyc=%0d got {err,pend,tick,pulse}=%b exp=%b", cyc, act, e);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called #1 after an edge; the write is sampled on the next edge.
    task automatic cfg_write(input logic [1:0] addr, input int ch, input int data);
        cfg_if.cfg_we   = 1'b1;
        cfg_if.cfg_addr = addr;
        cfg_if.cfg_ch   = ch[1:0];
        cfg_if.cfg_data = data[CNT_W-1:0];
        @(posedge clk);
        #1;
        cfg_if.cfg_we   = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        sync  = 1'b0;
        cfg_if.cfg_we   = 1'b0;
        cfg_if.cfg_addr = '0;
        cfg_if.cfg_ch   = '0;
        cfg_if.cfg_data = '0;

        // Reset state, then default operation: tick every 20, pulses 1..5.
        push_exp(0, '0);
        for (int i = 0; i < CH; i++) set_win(i, 1, 5);
        push_period(1,  20, '0, NONE, 0, NONE);
        push_period(21, 20, '0, NONE, 0, NONE);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Mid-period delay/width write on ch1: current period unchanged.
        wait_cyc(40);
        push_period(41, 20, '0, 6, 19, NONE);
        wait_cyc(45);
        cfg_write(2'd1, 1, 7);
        cfg_write(2'd2, 1, 4);

        // ch1 now 8..11; queue period=10, ch0 delay 8 width 6.
        wait_cyc(60);
        set_win(1, 8, 11);
        push_period(61, 20, '0, 6, 19, NONE);
        wait_cyc(65);
        cfg_write(2'd0, 0, 10);
        cfg_write(2'd1, 0, 8);
        cfg_write(2'd2, 0, 6);

        // Period 10 with truncated windows; restore period 20 mid-period.
        wait_cyc(80);
        set_win(0, 9, 10);
        set_win(1, 8, 10);
        push_period(81, 10, '0, NONE, 0, NONE);
        push_period(91, 10, '0, 4, 9, NONE);
        wait_cyc(93);
        cfg_write(2'd0, 0, 20);

        // Sync at cnt=13: outputs zero next cycle, tick the cycle after.
        wait_cyc(100);
        set_win(0, 9, 14);
        set_win(1, 8, 11);
        push_period(101, 13, '0, NONE, 0, NONE);
        push_exp(114, '0);
        push_period(115, 20, '0, NONE, 0, NONE);
        push_period(135, 20, '0, NONE, 0, NONE);
        wait_cyc(113);
        sync = 1'b1;
        @(posedge clk);
        #1 sync = 1'b0;

        // Invalid writes: period=1 and channel 3 -> ignored, sticky error.
        wait_cyc(154);
        push_period(155, 20, '0, NONE, 0, 4);
        push_period(175, 20, '0, NONE, 0, 0);
        wait_cyc(157);
        cfg_write(2'd0, 0, 1);
        cfg_write(2'd1, 3, 5);

        // Reset mid-pulse: immediate zero, config back to defaults.
        wait_cyc(194);
        push_period(195, 2, '0, NONE, 0, 0);
        push_exp(197, '0);
        for (int i = 0; i < CH; i++) set_win(i, 1, 5);
        push_period(198, 20, '0, NONE, 0, NONE);
        wait_cyc(197);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Polarity write on ch0, then disable.
        wait_cyc(217);
`ifdef PULSE_GEN_POL_EN
        push_period(218, 20, '0, 4, 19, NONE);
        push_period(238, 20, 3'b001, NONE, 0, NONE);
        for (int c = 258; c <= 260; c++) push_exp(c, 6'b000_001);
`else
        push_period(218, 20, '0, NONE, 0, NONE);
        push_period(238, 20, '0, NONE, 0, NONE);
        for (int c = 258; c <= 260; c++) push_exp(c, 6'b000_000);
`endif
        wait_cyc(220);
        cfg_write(2'd3, 0, 1);
        wait_cyc(257);
        en = 1'b0;
        wait_cyc(262);

        while (exp_q.size() > 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL unchecked_vector cyc=%0d exp=%b", exp_cyc_q.pop_front(), exp_q.pop_front());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL timeout cyc=%0d required=finish", cyc);
        $fatal(1, "timeout");
    end

endmodule
